pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Sits beside the hazard detector.

---
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the stall/flush sequencer and the datapath.
// master = sequencer side (consumes requests, drives enables); slave = datapath side.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             haz_stall;
    logic             br_taken;
    logic             jmp;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             haz_timeout;

    modport master (
        input  haz_stall, br_taken, jmp, dmem_req, dmem_ready, halt_req,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we,
        output halted, stall_cnt, flush_cnt, haz_timeout
    );

    modport slave (
        output haz_stall, br_taken, jmp, dmem_req, dmem_ready, halt_req,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we,
        input  halted, stall_cnt, flush_cnt, haz_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, redirect, dmem-wait
// and halt requests into per-stage enables, with saturating perf counters and a stall watchdog.
module pipe_ctrl #(
    parameter int CNT_W         = 32,
    parameter int MAX_HAZ_STALL = 3
) (
    input logic         clk,
    input logic         reset_n,
    pipe_ctrl_if.master bus
);

    localparam int CONS_W = $clog2(MAX_HAZ_STALL + 2);
    localparam logic [CONS_W-1:0] CONS_LIM = CONS_W'(MAX_HAZ_STALL + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CONS_W-1:0]  consec_q, consec_d;
    logic               haz_timeout_q, haz_timeout_d;
    logic               halted_q, halted_d;

    logic pc_we_c, if_id_we_c, if_id_flush_c, id_ex_bubble_c, ex_mem_we_c, mem_wb_we_c;
    logic stall_applied_c;
    logic run_eval_c;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CONS_W-1:0] sat_inc_consec(input logic [CONS_W-1:0] v);
        return (v == CONS_LIM) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            consec_q      <= '0;
            haz_timeout_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            consec_q      <= consec_d;
            haz_timeout_q <= haz_timeout_d;
            halted_q      <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.halt_req)
                    state_d = HALTED;
                else if (bus.dmem_req && !bus.dmem_ready)
                    state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.dmem_ready)
                    state_d = RUN;
            end
            default: state_d = HALTED;
        endcase
    end

    // Redirect/stall resolution applies in RUN when not frozen, and in the MEM_WAIT exit cycle.
    always_comb begin
        pc_we_c         = 1'b0;
        if_id_we_c      = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        ex_mem_we_c     = 1'b0;
        mem_wb_we_c     = 1'b0;
        stall_applied_c = 1'b0;
        run_eval_c      = 1'b0;

        case (state_q)
            RUN:      run_eval_c = !bus.halt_req && !(bus.dmem_req && !bus.dmem_ready);
            MEM_WAIT: run_eval_c = bus.dmem_ready;
            default:  run_eval_c = 1'b0;
        endcase

        if (run_eval_c) begin
            ex_mem_we_c = 1'b1;
            mem_wb_we_c = 1'b1;
            if (bus.br_taken) begin
                pc_we_c        = 1'b1;
                if_id_we_c     = 1'b1;
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
            end else if (bus.haz_stall) begin
                // A pending jump waits behind the stall: its rs may not be ready yet.
                id_ex_bubble_c  = 1'b1;
                stall_applied_c = 1'b1;
            end else if (bus.jmp) begin
                pc_we_c       = 1'b1;
                if_id_we_c    = 1'b1;
                if_id_flush_c = 1'b1;
            end else begin
                pc_we_c    = 1'b1;
                if_id_we_c = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d   = stall_applied_c ? sat_inc_cnt(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d   = if_id_flush_c ? sat_inc_cnt(flush_cnt_q) : flush_cnt_q;
        consec_d      = stall_applied_c ? sat_inc_consec(consec_q) : '0;
        haz_timeout_d = haz_timeout_q | (consec_d == CONS_LIM);
        halted_d      = halted_q | (state_d == HALTED);
    end

    // Reset is asynchronous, so the enables are gated directly to drop in the same instant.
    assign bus.pc_we        = reset_n & pc_we_c;
    assign bus.if_id_we     = reset_n & if_id_we_c;
    assign bus.if_id_flush  = reset_n & if_id_flush_c;
    assign bus.id_ex_bubble = reset_n & id_ex_bubble_c;
    assign bus.ex_mem_we    = reset_n & ex_mem_we_c;
    assign bus.mem_wb_we    = reset_n & mem_wb_we_c;
    assign bus.halted       = halted_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
    assign bus.haz_timeout  = haz_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 32-bit-counter instance with the default watchdog and a
// 4-bit-counter instance with the watchdog pushed out of reach for saturation.
module tb_pipe_ctrl;

    logic clk;
    logic reset_n;

    pipe_ctrl_if #(.CNT_W(32)) m_if ();
    pipe_ctrl_if #(.CNT_W(4))  s_if ();

    pipe_ctrl #(.CNT_W(32), .MAX_HAZ_STALL(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (m_if.master)
    );

    pipe_ctrl #(.CNT_W(4), .MAX_HAZ_STALL(100)) dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (s_if.master)
    );

    // Expected vector: {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted}
    localparam logic [6:0] E_OFF    = 7'b000000_0;
    localparam logic [6:0] E_NORM   = 7'b110011_0;
    localparam logic [6:0] E_STALL  = 7'b000111_0;
    localparam logic [6:0] E_BR     = 7'b111111_0;
    localparam logic [6:0] E_JMP    = 7'b111011_0;
    localparam logic [6:0] E_HALTED = 7'b000000_1;

    // Input vector: {halt_req, dmem_req, dmem_ready, br_taken, haz_stall, jmp}
    localparam logic [5:0] I_IDLE = 6'b000000;
    localparam logic [5:0] I_HAZ  = 6'b000010;
    localparam logic [5:0] I_JMP  = 6'b000001;

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [6:0] obs_main();
        return {m_if.pc_we, m_if.if_id_we, m_if.if_id_flush, m_if.id_ex_bubble,
                m_if.ex_mem_we, m_if.mem_wb_we, m_if.halted};
    endfunction

    function automatic logic [6:0] obs_sat();
        return {s_if.pc_we, s_if.if_id_we, s_if.if_id_flush, s_if.id_ex_bubble,
                s_if.ex_mem_we, s_if.mem_wb_we, s_if.halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic [6:0] obs);
        logic [6:0] expv;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            expv = exp_q.pop_front();
            chk(tag, {25'd0, obs}, {25'd0, expv});
        end
    endtask

    task automatic drive(input logic [5:0] iv);
        m_if.halt_req   = iv[5];
        m_if.dmem_req   = iv[4];
        m_if.dmem_ready = iv[3];
        m_if.br_taken   = iv[2];
        m_if.haz_stall  = iv[1];
        m_if.jmp        = iv[0];
    endtask

    // Called at posedge+1: drive, sample on the falling edge, then advance past the next edge.
    task automatic step(input logic [5:0] iv, input logic [6:0] expv, input string tag);
        drive(iv);
        exp_q.push_back(expv);
        @(negedge clk);
        pop_cmp(tag, obs_main());
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(I_IDLE);
        s_if.halt_req = 1'b0; s_if.dmem_req = 1'b0; s_if.dmem_ready = 1'b0;
        s_if.br_taken = 1'b0; s_if.haz_stall = 1'b0; s_if.jmp = 1'b0;

        #3;
        chk("rst_ctl", {25'd0, obs_main()}, {25'd0, E_OFF});
        chk("rst_stall_cnt", m_if.stall_cnt, 32'd0);
        chk("rst_flush_cnt", m_if.flush_cnt, 32'd0);
        chk("rst_timeout", {31'd0, m_if.haz_timeout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted in the middle of a stall
        step(I_HAZ, E_STALL, "t1_stall0");
        step(I_HAZ, E_STALL, "t1_stall1");
        chk("t1_cnt_before", m_if.stall_cnt, 32'd2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t1_ctl_in_reset", {25'd0, obs_main()}, {25'd0, E_OFF});
        chk("t1_cnt_in_reset", m_if.stall_cnt, 32'd0);
        drive(I_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(I_IDLE, E_NORM, "t1_run_after");
        chk("t1_cnt_after", m_if.stall_cnt, 32'd0);

        // Load-use stalls and the watchdog
        step(I_HAZ, E_STALL, "t2_stall0");
        step(I_HAZ, E_STALL, "t2_stall1");
        step(I_HAZ, E_STALL, "t2_stall2");
        chk("t2_cnt3", m_if.stall_cnt, 32'd3);
        chk("t2_timeout_clear", {31'd0, m_if.haz_timeout}, 32'd0);
        step(I_HAZ, E_STALL, "t2_stall3");
        chk("t2_cnt4", m_if.stall_cnt, 32'd4);
        chk("t2_timeout_set", {31'd0, m_if.haz_timeout}, 32'd1);
        step(I_IDLE, E_NORM, "t2_release0");
        step(I_IDLE, E_NORM, "t2_release1");
        chk("t2_timeout_sticky", {31'd0, m_if.haz_timeout}, 32'd1);

        // Branch outranks stall and jump; jump alone; jump held behind stall
        step(6'b000111, E_BR, "t3_br_all");
        chk("t3_stall_cnt", m_if.stall_cnt, 32'd4);
        chk("t3_flush_cnt", m_if.flush_cnt, 32'd1);
        step(I_JMP, E_JMP, "t3_jmp");
        chk("t3_flush_cnt_jmp", m_if.flush_cnt, 32'd2);
        step(6'b000011, E_STALL, "t3_haz_jmp");
        chk("t3_stall_cnt_hj", m_if.stall_cnt, 32'd5);
        chk("t3_flush_cnt_hj", m_if.flush_cnt, 32'd2);

        // Data-memory wait freezes everything, branch during the wait is ignored
        step(6'b010100, E_OFF, "t4_wait0");
        step(6'b010100, E_OFF, "t4_wait1");
        step(6'b010100, E_OFF, "t4_wait2");
        step(6'b011000, E_NORM, "t4_ready");
        step(I_IDLE, E_NORM, "t4_after");
        chk("t4_flush_cnt", m_if.flush_cnt, 32'd2);
        chk("t4_stall_cnt", m_if.stall_cnt, 32'd5);

        // Halt outranks branch and is terminal
        step(6'b100100, E_OFF, "t5_halt");
        for (int i = 0; i < 12; i++) begin
            logic [5:0] iv;
            iv = 6'($urandom_range(0, 63));
            step(iv, E_HALTED, $sformatf("t5_halted%0d", i));
        end
        chk("t5_flush_cnt", m_if.flush_cnt, 32'd2);
        chk("t5_stall_cnt", m_if.stall_cnt, 32'd5);

        // Saturation on the 4-bit instance
        drive(I_IDLE);
        pulse_reset();
        chk("t6_main_run", {25'd0, obs_main()}, {25'd0, E_NORM});
        for (int i = 0; i < 20; i++) begin
            s_if.haz_stall = 1'b1;
            exp_q.push_back(E_STALL);
            @(negedge clk);
            pop_cmp($sformatf("t6_sat_ctl%0d", i), obs_sat());
            @(posedge clk);
            #1;
            chk($sformatf("t6_sat_cnt%0d", i), {28'd0, s_if.stall_cnt},
                (i + 1 < 15) ? 32'(i + 1) : 32'd15);
        end
        s_if.haz_stall = 1'b0;
        chk("t6_sat_final", {28'd0, s_if.stall_cnt}, 32'd15);
        chk("t6_sat_timeout", {31'd0, s_if.haz_timeout}, 32'd0);
        chk("t6_main_cnt", m_if.stall_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
